seq_divider: RTL
================

// Module: seq_divider
// PURPOSE
//  Multi-cycle restoring divider: the inverse datapath of the sequential multiplier.
//  Takes a 2W-bit dividend (product width) and a W-bit divisor; returns the quotient and remainder.
//  Uses the same valid/DONE handshake style as the multiplier top.
//  Sits beside the multiplier so a product can be fed back and checked (prod / B == A, rem 0).
// PARAMETERS
//  W  4  divisor/remainder width; dividend and quotient are 2*W bits
// PORTS
//  clk       in   1    single clock, rising edge
//  rst       in   1    asynchronous, active-low reset (0 = reset)
//  valid     in   1    start request; sampled only in IDLE
//  dividend  in   2W   numerator, MSB-first in iterations
//  divisor   in   W    denominator
//  quot      out  2W   quotient, registered
//  rem       out  W    remainder, registered
//  div_zero  out  1    divisor was 0 for the current result
//  busy      out  1    high whenever state != IDLE
//  DONE      out  1    one-cycle pulse: quot/rem/div_zero are valid
// BEHAVIOUR
//  Reset (rst=0, any time, async):
//   - state=IDLE; quot, rem, div_zero, DONE, busy all 0; internal regs cleared.
//  FSM states:
//   - IDLE: valid=1 at edge E0 and divisor!=0 -> latch operands, P=0, cnt=0 -> CALC.
//   - IDLE: valid=1 at edge E0 and divisor==0 -> FIN; quot=all-ones, rem=0, div_zero=1.
//   - CALC: one quotient bit per edge, 2W edges. Each edge:
//       P' = {P[W-1:0], next dividend bit} (W+1 bits); if P' >= divisor then
//       P = P' - divisor, qbit=1 else P = P', qbit=0. qbit shifts into the quotient LSB.
//   - CALC: on the 2W-th edge (cnt == 2W-1), load quot/rem and set div_zero=0 -> FIN.
//   - FIN: DONE=1 for exactly this one cycle -> IDLE on the next edge.
//  Latency:
//   - Normal: DONE is high in the cycle after edge E0+2W (2W+1 edges after valid is sampled).
//   - Divide by zero: DONE is high in the cycle after E0.
//  Output rules:
//   - quot/rem/div_zero change only on entry to FIN.
//   - They hold until the next entry to FIN, so they stay stable after DONE drops.
//  Handshake:
//   - valid is level-sampled in IDLE only; it is ignored in CALC and FIN.
//   - Operands are not re-read after E0, so input changes mid-operation have no effect.
//   - If valid is held high continuously, a new operation starts on the edge after FIN (IDLE sees it).
//   - busy=1 in CALC and FIN; busy=0 in IDLE. DONE is never high in IDLE.
//  Width rules:
//   - Unsigned only. 2W-bit quotient never overflows for divisor>=1.
//   - rem < divisor always.
//   - The W+1-bit partial remainder avoids compare overflow.
//  Reset mid-operation:
//   - Result aborts with no DONE; outputs return to 0.
//   - The first valid after release starts a fresh operation.
// TESTING (W=4)
//  - 49/7 (dividend=8'h31, divisor=4'h7), 1-cycle valid -> DONE 9 edges later; quot=8'h07, rem=4'h0, div_zero=0.
//  - 200/15 -> quot=8'd13, rem=4'd5; 255/1 -> quot=8'hFF, rem=0; 3/9 -> quot=0, rem=3.
//  - divisor=0, dividend=100 -> DONE in the cycle after the sample edge; quot=8'hFF, rem=0, div_zero=1.
//  - New valid with 50/5 during CALC of 49/7 -> ignored; result stays 7 r0; busy high throughout.
//  - rst=0 for 1 cycle midway through 200/15 -> outputs 0 immediately, no DONE;
//    then 49/7 -> 7 r0 with normal latency.
//  - valid held high for 30 cycles with 49/7 -> DONE pulses every 10 cycles, each 7 r0;
//    DONE never wider than 1 cycle.

Source files
------------

// File: rtl/seq_divider_if.sv
// seq_divider_if: start/operand and result/DONE bundle for the sequential restoring divider.
interface seq_divider_if #(parameter int W = 4);
    logic           valid;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic [2*W-1:0] quot;
    logic [W-1:0]   rem;
    logic           div_zero;
    logic           busy;
    logic           DONE;
    modport master (output valid, dividend, divisor, input quot, rem, div_zero, busy, DONE);
    modport slave  (input valid, dividend, divisor, output quot, rem, div_zero, busy, DONE);
endinterface

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, 2W-bit dividend by W-bit divisor, one quotient bit per cycle.
module seq_divider #(parameter int W = 4) (
    input logic     clk,
    input logic     rst,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(2 * W);
    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
    state_t         state, nxt;
    logic [W-1:0]   p, dsr, rem_r, pn;
    logic [2*W-1:0] dvd, q, quot_r;
    logic [CW-1:0]  cnt;
    logic [W:0]     pt;
    logic           dz, ge, last;
    // The partial remainder is always below the divisor, so W-bit subtraction gives the exact result.
    always_comb begin
        pt   = {p, dvd[2*W-1]};
        ge   = pt >= {1'b0, dsr};
        pn   = ge ? pt[W-1:0] - dsr : pt[W-1:0];
        last = cnt == CW'(2 * W - 1);
    end
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (bus.valid) nxt = (bus.divisor == '0) ? FIN : CALC;
            CALC:    if (last) nxt = FIN;
            FIN:     nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p      <= '0;
            dsr    <= '0;
            dvd    <= '0;
            q      <= '0;
            cnt    <= '0;
            quot_r <= '0;
            rem_r  <= '0;
            dz     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (bus.valid) begin
                    dvd <= bus.dividend;
                    dsr <= bus.divisor;
                    p   <= '0;
                    q   <= '0;
                    cnt <= '0;
                    if (bus.divisor == '0) begin
                        quot_r <= '1;
                        rem_r  <= '0;
                        dz     <= 1'b1;
                    end
                end
                CALC: begin
                    p   <= pn;
                    dvd <= {dvd[2*W-2:0], 1'b0};
                    q   <= {q[2*W-2:0], ge};
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        quot_r <= {q[2*W-2:0], ge};
                        rem_r  <= pn;
                        dz     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
    assign bus.quot     = quot_r;
    assign bus.rem      = rem_r;
    assign bus.div_zero = dz;
    assign bus.busy     = state != IDLE;
    assign bus.DONE     = state == FIN;
endmodule
